// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier.
module ex_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            hi_wr,
  input  logic            lo_wr,
  input  logic [XLEN-1:0] wdata,
  input  logic            rd_hilo,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned    CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e              state_q, state_d;
  logic                is_div_q, is_div_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;

  // Operand conditioning at start: unsigned ops never carry a sign.
  logic            sign_a_in, sign_b_in;
  logic [XLEN-1:0] abs_a, abs_b;
  assign sign_a_in = ~op[0] & src_a[XLEN-1];
  assign sign_b_in = ~op[0] & src_b[XLEN-1];
  assign abs_a     = sign_a_in ? -src_a : src_a;
  assign abs_b     = sign_b_in ? -src_b : src_b;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{sign_a_in}}, src_a} * {{XLEN{sign_b_in}}, src_b};
`else
  localparam bit FastMul = 1'b0;
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = '0;
`endif

  // Shift-add multiply: acc = {partial product, remaining multiplier bits}.
  logic [XLEN-1:0]   mul_add;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_add  = acc_q[0] ? a_q : '0;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_step;
  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
  assign div_step  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, raw_a;
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign raw_a    = sign_a_q ? -a_q : a_q;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (FastMul && !op[1]) begin
            {hi_d, lo_d} = fast_prod;
            done_d       = 1'b1;
          end else begin
            is_div_d = op[1];
            sign_a_d = sign_a_in;
            sign_b_d = sign_b_in;
            a_d      = abs_a;
            b_d      = abs_b;
            cnt_d    = '0;
            acc_d    = {{XLEN{1'b0}}, op[1] ? abs_a : abs_b};
            state_d  = StCalc;
          end
        end else begin
          if (hi_wr) hi_d = wdata;
          if (lo_wr) lo_d = wdata;
        end
      end
      StCalc: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_q == '0) begin
          lo_d = '1;
          hi_d = raw_a;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A flushed instruction leaves no architectural trace.
    if (flush) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign stall = busy & (start | rd_hilo | hi_wr | lo_wr);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table, random unsigned/signed ops
// and hand-written stall, flush and reset sequences, with a result scoreboard.
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, hi_wr, lo_wr, rd_hilo, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[12];

  ex_muldiv #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wdata   (wdata),
    .rd_hilo (rd_hilo),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected done: got hi:lo %h%h, expected no result", hi, lo);
      end else begin
        check("result hi:lo", {hi, lo}, sb.pop_front());
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string name,
                        input bit wr);
    int          busy_n;
    int          exp_busy;
    logic [63:0] prev;
    @(negedge clk);
    prev  = {hi, lo};
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (wr) begin
      hi_wr = 1'b1;
      lo_wr = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    sb.push_back({eh, el});
    exp_busy = (FastMul && !o[1]) ? 0 : 33;
    @(negedge clk);
    start = 1'b0;
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    if (wr) check({name, " writes dropped on start"}, {hi, lo}, prev);
    busy_n = 0;
    while (busy && busy_n < 100) begin
      busy_n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, 64'(busy_n), 64'(exp_busy));
    check({name, " done pulse"}, {63'd0, done}, 64'd1);
    @(negedge clk);
    check({name, " done single"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max"};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3*7"};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
    vecs[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu 7/2"};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div ovf"};
    vecs[5]  = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "divu 5/0"};
    vecs[6]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div -7/0"};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult min*min"};
    vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, "divu max/16"};
    vecs[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2"};
    vecs[10] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "multu 2^32"};
    vecs[11] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult -1*-1"};

    rst_n   = 1'b0;
    start   = 1'b0;
    hi_wr   = 1'b0;
    lo_wr   = 1'b0;
    rd_hilo = 1'b0;
    flush   = 1'b0;
    op      = 2'b00;
    src_a   = '0;
    src_b   = '0;
    wdata   = '0;
    #12;
    check("reset hi:lo", {hi, lo}, 64'd0);
    check("reset busy/done/stall", {61'd0, busy, done, stall}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI / MTLO in IDLE
    @(negedge clk);
    hi_wr = 1'b1;
    wdata = 32'h1111_1111;
    @(negedge clk);
    hi_wr = 1'b0;
    check("mthi", {hi, lo}, {32'h1111_1111, 32'h0});
    lo_wr = 1'b1;
    wdata = 32'h2222_2222;
    @(negedge clk);
    lo_wr = 1'b0;
    check("mtlo", {hi, lo}, {32'h1111_1111, 32'h2222_2222});
    hi_wr = 1'b1;
    lo_wr = 1'b1;
    wdata = 32'h3333_3333;
    @(negedge clk);
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    check("mthi+mtlo", {hi, lo}, {32'h3333_3333, 32'h3333_3333});

    // start beats a simultaneous write
    run_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, "start+write", 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b, eh, el;
      logic [63:0] p;
      o = 2'(i % 4);
      a = $urandom;
      b = $urandom;
      if (o[1] && (i % 8 >= 4)) b = b >> 28;
      if (o[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) a = 32'h7FFF_FFFF;
      case (o)
        2'b00: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        2'b01: p = {32'd0, a} * {32'd0, b};
        2'b10: begin
          if (b == 0) p = {a, 32'hFFFF_FFFF};
          else begin
            eh = $signed(a) % $signed(b);
            el = $signed(a) / $signed(b);
            p  = {eh, el};
          end
        end
        default: begin
          if (b == 0) p = {a, 32'hFFFF_FFFF};
          else p = {a % b, a / b};
        end
      endcase
      run_op(o, a, b, p[63:32], p[31:0], "rand", 1'b0);
    end

    // DIV in flight; MFHI/MFLO request from cycle 10 must stall until busy falls.
    begin
      int cyc;
      int bad;
      cyc = 1;
      bad = 0;
      @(negedge clk);
      start = 1'b1;
      op    = 2'b10;
      src_a = 32'hFFFF_FF9C;
      src_b = 32'd7;
      sb.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
      @(negedge clk);
      start = 1'b0;
      while (busy && cyc < 100) begin
        if (cyc == 10) rd_hilo = 1'b1;
        if (cyc == 12) begin
          hi_wr = 1'b1;
          wdata = 32'h0000_FFFF;
        end
        if (cyc == 13) hi_wr = 1'b0;
        #1;
        if ((cyc >= 10) != stall) bad++;
        cyc++;
        @(negedge clk);
      end
      check("stall seq busy len", 64'(cyc), 64'd34);
      check("stall while busy", 64'(bad), 64'd0);
      #1;
      check("stall after busy", {63'd0, stall}, 64'd0);
      check("mflo quotient", {32'd0, lo}, {32'd0, 32'hFFFF_FFF2});
      check("hi_wr during busy", {32'd0, hi}, {32'd0, 32'hFFFF_FFFE});
      rd_hilo = 1'b0;
    end

    // Flush mid-DIV keeps HI/LO and never pulses done.
    begin
      int dn;
      dn = 0;
      @(negedge clk);
      hi_wr = 1'b1;
      wdata = 32'h0000_1234;
      @(negedge clk);
      hi_wr = 1'b0;
      lo_wr = 1'b1;
      wdata = 32'h0000_5678;
      @(negedge clk);
      lo_wr = 1'b0;
      start = 1'b1;
      op    = 2'b10;
      src_a = 32'd100;
      src_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush idle", {63'd0, busy}, 64'd0);
      check("flush hi:lo", {hi, lo}, {32'h0000_1234, 32'h0000_5678});
      repeat (40) begin
        @(negedge clk);
        if (done) dn++;
      end
      check("flush no done", 64'(dn), 64'd0);
      start = 1'b1;
      flush = 1'b1;
      op    = 2'b11;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush+start ignored", {63'd0, busy}, 64'd0);
    end

    // Async reset mid-MULT clears HI/LO and busy at once.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'd3;
    src_b = 32'd5;
    if (FastMul) sb.push_back({32'd0, 32'd15});
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset mid-op hi:lo", {hi, lo}, 64'd0);
    check("reset mid-op busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded operands and mult/div control from ID/EX and owns the architectural HI/LO registers.
- Asserts a stall to the hazard logic while an operation is in flight and a dependent instruction needs it.
- Handles MULT, MULTU, DIV, DIVU, MTHI, MTLO, and provides HI/LO for MFHI/MFLO.

Parameters:
XLEN, 32, operand/HI/LO width; only 32 is verified.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  EX-stage instruction is mult/div; sampled only in IDLE.
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
src_a  in  32  rs operand (forwarded busA).
src_b  in  32  rt operand (forwarded busB).
hi_wr  in  1  MTHI: write wdata into HI.
lo_wr  in  1  MTLO: write wdata into LO.
wdata  in  32  MTHI/MTLO data.
rd_hilo  in  1  EX-stage instruction is MFHI/MFLO.
flush  in  1  kill the in-flight operation (exception/branch bubble).
busy  out  1  operation in flight.
stall  out  1  freeze IF/ID/ID-EX this cycle.
done  out  1  one-cycle pulse after HI/LO update from an operation.
hi  out  32  HI register.
lo  out  32  LO register.

Behaviour:
- Reset (async, rst_n=0): state IDLE; hi=0, lo=0, busy=0, done=0, internal counter/accumulators=0. Reset mid-operation aborts it; HI/LO still clear to 0.
- States and transitions:
  - IDLE: on an edge with start=1 (and no flush), latch op, the operand signs and abs(src_a)/abs(src_b) (raw values for unsigned ops), clear counter and partial remainder/product, go to CALC.
  - CALC: one radix-2 step per edge (shift-add for mult, restoring shift-subtract for div), counter 0..31. The edge with counter=31 goes to FIX.
  - FIX: one edge applies sign correction, writes HI/LO, returns to IDLE. done=1 for the cycle after that edge.
- Latency: start sampled at edge E0; HI/LO updated at edge E0+33. busy is high from E0 through E0+33, i.e. 33 cycles.
- Mult: {hi,lo} = 64-bit product. For MULT the product is negated iff the operand signs differ.
- Div: lo = quotient, hi = remainder.
  - DIV: quotient negated iff signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
- Divide by zero (either op): lo=0xFFFFFFFF, hi=src_a as latched (original, not abs). Full 33-cycle latency still applies.
- stall = busy & (start | rd_hilo | hi_wr | lo_wr). Combinational, no extra cycle.
- Requests while busy:
  - start is ignored; upstream holds the instruction via stall.
  - hi_wr/lo_wr while busy are not applied.
  - rd_hilo sees the final HI/LO on the first cycle with busy=0.
- hi_wr/lo_wr in IDLE update HI/LO at that edge. hi_wr and lo_wr together write both.
- start and hi_wr/lo_wr on the same edge in IDLE: start wins, writes are dropped.
- flush: flush=1 at any edge forces IDLE. HI/LO are unchanged, done stays 0, and a start sampled on that same edge is ignored.
- The unit never changes HI/LO except at FIX, on hi_wr/lo_wr in IDLE, or on reset.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: MULT/MULTU compute with a single-cycle multiplier. HI/LO are written at E0, done pulses in the next cycle, busy never asserts for mult, and stall stays 0 for mult. Divide behaviour is unchanged (33 cycles).
- Not defined: mult uses the iterative 33-cycle path described above.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 busy cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses once. With MULDIV_FAST_MUL_EN: same values at E0, busy=0.
- MULT 0xFFFFFFFD(-3) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5 at E0+33.
- DIV in flight with rd_hilo=1 at cycle 10 -> stall=1 until busy falls. MFLO then sees the quotient. A hi_wr during busy leaves HI = remainder.
- Flush at cycle 15 of a DIV with prior hi=0x1234, lo=0x5678 -> IDLE next cycle, HI/LO unchanged, no done. Separately, rst_n low at cycle 20 of a MULT -> hi=lo=0, busy=0 immediately.
